video_stream_gen: RTL and testbench



---
 rtl/video_pkg.sv | 26 ++
 rtl/video_pattern_unit.sv | 42 ++++
 rtl/video_stream_gen.sv | 157 +++++++++++++++
 tb/tb_video_stream_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the raster video source.
// Pure declarations: no latency, no backpressure.
package video_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VBP  = 3'd1,
    S_ACT  = 3'd2,
    S_HBL  = 3'd3,
    S_VFP  = 3'd4
  } state_t;

  localparam logic [1:0] PAT_INDEX = 2'd0;
  localparam logic [1:0] PAT_COL   = 2'd1;
  localparam logic [1:0] PAT_ROW   = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Ceil-log2, but never below 1 so that single-value counters keep a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/video_pattern_unit.sv
// Registered test-pattern datapath: one cycle from (mode,x,y,idx,active) to o_dout.
// No backpressure; o_dout is forced to 0 whenever i_active is low.
module video_pattern_unit
  import video_pkg::*;
#(
  parameter int DW = 8,
  parameter int XW = 2,
  parameter int YW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    i_mode,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [DW-1:0] i_idx,
  input  logic          i_active,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] w_pix;
  logic [DW-1:0] r_dout;

  always_comb begin
    w_pix = '0;
    case (i_mode)
      PAT_INDEX: w_pix = i_idx;
      PAT_COL:   w_pix = DW'(i_x);
      PAT_ROW:   w_pix = DW'(i_y);
      PAT_CHECK: w_pix = (i_x[0] ^ i_y[0]) ? '1 : '0;
      default:   w_pix = '0;
    endcase
    if (!i_active) w_pix = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= '0;
    else        r_dout <= w_pix;
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/video_stream_gen.sv
// Raster frame generator (vsync/hsync/data) with selectable test patterns; outputs registered.
// No backpressure: start is only sampled in IDLE and is otherwise dropped, never queued.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int DW  = 8,
  parameter int W   = 4,
  parameter int H   = 2,
  parameter int VBP = 8,
  parameter int HB  = 5,
  parameter int VFP = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          dout_vsync,
  output logic          dout_hsync,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          frame_done
);

  localparam int XW   = clog2(W);
  localparam int YW   = clog2(H);
  localparam int PMAX = (VBP > HB) ? ((VBP > VFP) ? VBP : VFP) : ((HB > VFP) ? HB : VFP);
  localparam int CW   = clog2(PMAX);

  localparam logic [XW-1:0] X_LAST   = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(H - 1);
  localparam logic [CW-1:0] VBP_LAST = CW'(VBP - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(HB - 1);
  localparam logic [CW-1:0] VFP_LAST = CW'(VFP - 1);

  state_t        r_state, w_nxt_state;
  logic [XW-1:0] r_x, w_nxt_x;
  logic [YW-1:0] r_y, w_nxt_y;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [DW-1:0] r_idx, w_nxt_idx;
  logic [1:0]    r_mode, w_nxt_mode;

  logic          r_vsync, r_hsync, r_done;
  logic          w_vsync_d, w_hsync_d, w_done_d;
  logic [DW-1:0] w_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_x     <= w_nxt_x;
      r_y     <= w_nxt_y;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
      r_mode  <= w_nxt_mode;
    end
  end

  // r_idx tracks y*W+x of the current pixel; it holds across HBL and wraps at 2^DW.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_x     = r_x;
    w_nxt_y     = r_y;
    w_nxt_cnt   = r_cnt;
    w_nxt_idx   = r_idx;
    w_nxt_mode  = r_mode;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_VBP;
          w_nxt_cnt   = '0;
          w_nxt_mode  = mode;
        end
      end
      S_VBP: begin
        if (r_cnt == VBP_LAST) begin
          w_nxt_state = S_ACT;
          w_nxt_x     = '0;
          w_nxt_y     = '0;
          w_nxt_idx   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_ACT: begin
        if (r_x == X_LAST) begin
          w_nxt_cnt   = '0;
          w_nxt_state = (r_y == Y_LAST) ? S_VFP : S_HBL;
        end else begin
          w_nxt_x   = r_x + 1'b1;
          w_nxt_idx = r_idx + 1'b1;
        end
      end
      S_HBL: begin
        if (r_cnt == HB_LAST) begin
          w_nxt_state = S_ACT;
          w_nxt_x     = '0;
          w_nxt_y     = r_y + 1'b1;
          w_nxt_idx   = r_idx + 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_VFP: begin
        if (r_cnt == VFP_LAST) w_nxt_state = S_IDLE;
        else                   w_nxt_cnt   = r_cnt + 1'b1;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered flags line up with it.
  always_comb begin
    w_vsync_d = (w_nxt_state != S_IDLE);
    w_hsync_d = (w_nxt_state == S_ACT);
    w_done_d  = (r_state == S_VFP) && (w_nxt_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_vsync <= w_vsync_d;
      r_hsync <= w_hsync_d;
      r_done  <= w_done_d;
    end
  end

  video_pattern_unit #(
    .DW(DW),
    .XW(XW),
    .YW(YW)
  ) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_mode   (w_nxt_mode),
    .i_x      (w_nxt_x),
    .i_y      (w_nxt_y),
    .i_idx    (w_nxt_idx),
    .i_active (w_hsync_d),
    .o_dout   (w_dout)
  );

  assign dout_vsync = r_vsync;
  assign dout_hsync = r_hsync;
  assign dout       = w_dout;
  assign busy       = r_vsync;
  assign frame_done = r_done;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: default-geometry and wide-line (W=300,H=1) instances
// checked every cycle against a frame-position model, plus directed literal checks.
module tb_video_stream_gen;

  localparam int VBP = 8;
  localparam int HB  = 5;
  localparam int VFP = 3;
  localparam int W1 = 4, H1 = 2;
  localparam int W2 = 300, H2 = 1;

  logic       clk;
  logic       rst_n;
  logic       start, start2;
  logic [1:0] mode, mode2;
  logic       vs1, hs1, busy1, done1;
  logic       vs2, hs2, busy2, done2;
  logic [7:0] d1, d2;

  int n_tests = 0;
  int n_fail  = 0;

  video_stream_gen dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dout_vsync(vs1), .dout_hsync(hs1), .dout(d1), .busy(busy1), .frame_done(done1)
  );

  video_stream_gen #(.DW(8), .W(W2), .H(H2), .VBP(VBP), .HB(HB), .VFP(VFP)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
    .dout_vsync(vs2), .dout_hsync(hs2), .dout(d2), .busy(busy2), .frame_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int flen(input int w, input int h);
    return VBP + h * w + (h - 1) * HB + VFP;
  endfunction

  // Expected outputs for a frame at cycle offset p from its acceptance edge.
  task automatic model_out(input int p, input int w, input int h, input int m,
                           output int vs, output int hs, output int d, output int dn);
    int len, q, line, col;
    len = flen(w, h);
    vs = (p < len) ? 1 : 0;
    dn = (p == len) ? 1 : 0;
    hs = 0;
    d  = 0;
    if (p >= VBP && p < len) begin
      q    = p - VBP;
      line = q / (w + HB);
      col  = q % (w + HB);
      if (line < h && col < w) begin
        hs = 1;
        case (m)
          0:       d = (line * w + col) & 255;
          1:       d = col & 255;
          2:       d = line & 255;
          default: d = (((col ^ line) & 1) != 0) ? 255 : 0;
        endcase
      end
    end
  endtask

  int p1 = flen(W1, H1) + 1;
  int p2 = flen(W2, H2) + 1;
  int m1 = 0;
  int m2 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 = flen(W1, H1) + 1;
      p2 = flen(W2, H2) + 1;
    end else begin
      if (p1 >= flen(W1, H1) && start) begin
        p1 = 0;
        m1 = int'(mode);
      end else if (p1 <= flen(W1, H1)) begin
        p1++;
      end
      if (p2 >= flen(W2, H2) && start2) begin
        p2 = 0;
        m2 = int'(mode2);
      end else if (p2 <= flen(W2, H2)) begin
        p2++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int vs, hs, d, dn;
    model_out(p1, W1, H1, m1, vs, hs, d, dn);
    chk("m1_vsync", 32'(vs1), vs);
    chk("m1_hsync", 32'(hs1), hs);
    chk("m1_dout", 32'(d1), d);
    chk("m1_busy", 32'(busy1), vs);
    chk("m1_done", 32'(done1), dn);
    model_out(p2, W2, H2, m2, vs, hs, d, dn);
    chk("m2_vsync", 32'(vs2), vs);
    chk("m2_hsync", 32'(hs2), hs);
    chk("m2_dout", 32'(d2), d);
    chk("m2_busy", 32'(busy2), vs);
    chk("m2_done", 32'(done2), dn);
  end

  // Returns at the negedge of cycle 0 (the first cycle after the acceptance edge).
  task automatic accept1(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vs"}, 32'(vs1), 0);
    chk({tag, "_hs"}, 32'(hs1), 0);
    chk({tag, "_d"}, 32'(d1), 0);
    chk({tag, "_busy"}, 32'(busy1), 0);
    chk({tag, "_done"}, 32'(done1), 0);
    chk({tag, "_vs2"}, 32'(vs2), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    mode   = 2'd0;
    mode2  = 2'd0;
    idle_cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // Default frame, mode 0.
    accept1(2'd0);
    for (int k = 0; k < 27; k++) begin
      if (k == 0)  chk("t1_vs0", 32'(vs1), 1);
      if (k == 0)  chk("t1_busy0", 32'(busy1), 1);
      if (k == 7)  chk("t1_hs7", 32'(hs1), 0);
      if (k == 8)  chk("t1_d8", 32'(d1), 0);
      if (k == 8)  chk("t1_hs8", 32'(hs1), 1);
      if (k == 11) chk("t1_d11", 32'(d1), 3);
      if (k == 12) chk("t1_hs12", 32'(hs1), 0);
      if (k == 17) chk("t1_d17", 32'(d1), 4);
      if (k == 20) chk("t1_d20", 32'(d1), 7);
      if (k == 21) chk("t1_d21", 32'(d1), 0);
      if (k == 23) chk("t1_vs23", 32'(vs1), 1);
      if (k == 24) chk("t1_vs24", 32'(vs1), 0);
      if (k == 24) chk("t1_busy24", 32'(busy1), 0);
      if (k == 24) chk("t1_done24", 32'(done1), 1);
      if (k == 25) chk("t1_done25", 32'(done1), 0);
      @(negedge clk);
    end

    // Modes 1, 2, 3.
    for (int m = 1; m <= 3; m++) begin
      accept1(2'(m));
      for (int k = 0; k < 27; k++) begin
        if (m == 1 && k == 10) chk("t2_col_x2", 32'(d1), 2);
        if (m == 1 && k == 20) chk("t2_col_x3y1", 32'(d1), 3);
        if (m == 2 && k == 9)  chk("t2_row_y0", 32'(d1), 0);
        if (m == 2 && k == 18) chk("t2_row_y1", 32'(d1), 1);
        if (m == 3 && k == 8)  chk("t2_chk_00", 32'(d1), 0);
        if (m == 3 && k == 9)  chk("t2_chk_10", 32'(d1), 255);
        if (m == 3 && k == 17) chk("t2_chk_01", 32'(d1), 255);
        if (m == 3 && k == 18) chk("t2_chk_11", 32'(d1), 0);
        @(negedge clk);
      end
    end

    // start held high: back-to-back frames with one vsync-low cycle.
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    for (int k = 0; k < 56; k++) begin
      if (k == 23) chk("t3_vs23", 32'(vs1), 1);
      if (k == 24) chk("t3_vs24", 32'(vs1), 0);
      if (k == 24) chk("t3_done24", 32'(done1), 1);
      if (k == 25) chk("t3_vs25", 32'(vs1), 1);
      if (k == 32) chk("t3_hs32", 32'(hs1), 0);
      if (k == 33) chk("t3_hs33", 32'(hs1), 1);
      if (k == 33) chk("t3_d33", 32'(d1), 0);
      if (k == 40) start = 1'b0;
      if (k == 49) chk("t3_done49", 32'(done1), 1);
      if (k == 52) chk("t3_vs52", 32'(vs1), 0);
      @(negedge clk);
    end

    // Stray start pulses mid-frame are dropped.
    accept1(2'd1);
    for (int k = 0; k < 32; k++) begin
      if (k == 3 || k == 15) start = 1'b1;
      if (k == 4 || k == 16) start = 1'b0;
      if (k == 24) chk("t3p_done24", 32'(done1), 1);
      if (k == 26) chk("t3p_vs26", 32'(vs1), 0);
      if (k == 30) chk("t3p_vs30", 32'(vs1), 0);
      @(negedge clk);
    end

    // Asynchronous reset mid line 0, then a clean restart.
    accept1(2'd0);
    idle_cycles(10);
    chk("t4_d10_pre", 32'(d1), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t4_async");
    idle_cycles(2);
    rst_n = 1'b1;
    accept1(2'd0);
    for (int k = 0; k < 27; k++) begin
      if (k == 8)  chk("t4_d8", 32'(d1), 0);
      if (k == 9)  chk("t4_d9", 32'(d1), 1);
      if (k == 20) chk("t4_d20", 32'(d1), 7);
      @(negedge clk);
    end

    // Mode change mid-frame is ignored.
    accept1(2'd0);
    for (int k = 0; k < 27; k++) begin
      if (k == 9)  mode = 2'd3;
      if (k == 10) chk("t6_d10", 32'(d1), 2);
      if (k == 19) chk("t6_d19", 32'(d1), 6);
      @(negedge clk);
    end
    mode = 2'd0;

    // Wide single-line frame: pixel index wraps at 256.
    @(negedge clk);
    start2 = 1'b1;
    mode2  = 2'd0;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 315; k++) begin
      if (k == 8)   chk("t5_d8", 32'(d2), 0);
      if (k == 263) chk("t5_d255", 32'(d2), 255);
      if (k == 264) chk("t5_wrap", 32'(d2), 0);
      if (k == 307) chk("t5_d43", 32'(d2), 43);
      if (k == 308) chk("t5_hs308", 32'(hs2), 0);
      if (k == 310) chk("t5_vs310", 32'(vs2), 1);
      if (k == 311) chk("t5_vs311", 32'(vs2), 0);
      if (k == 311) chk("t5_done311", 32'(done2), 1);
      @(negedge clk);
    end

    // Randomized traffic on both instances, with rare async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      mode   = 2'($urandom_range(0, 3));
      start2 = ($urandom_range(0, 63) == 0);
      mode2  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    start  = 1'b0;
    start2 = 1'b0;
    idle_cycles(330);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
